// File: rtl/uart_imem_loader.sv
// UART program loader: receives a framed image over a serial line, writes it word by word
// into instruction memory and holds the CPU in reset until a frame's checksum verifies.
module uart_imem_loader #(
    parameter int CLK_HZ      = 100000000,
    parameter int BAUD        = 115200,
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              uart_rx_i,
    input  logic              load_en_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              cpu_rstn_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int DIV    = CLK_HZ / BAUD;
    localparam int HALF   = DIV / 2;
    localparam int BAUD_W = $clog2(DIV);
    localparam int TMR_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

    // ------------------------------------------------------------------ UART receiver
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

    rxState_t          rxState, rxStateNext;
    logic              rxMeta, rxSync, rxPrev;
    logic [BAUD_W-1:0] baudCnt, baudCntNext;
    logic [2:0]        bitCnt, bitCntNext;
    logic [7:0]        rxShift, rxShiftNext;
    logic              byteValid, frameErr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rxMeta  <= 1'b1;
            rxSync  <= 1'b1;
            rxPrev  <= 1'b1;
            rxState <= RX_IDLE;
            baudCnt <= '0;
            bitCnt  <= '0;
            rxShift <= '0;
        end else begin
            rxMeta  <= uart_rx_i;
            rxSync  <= rxMeta;
            rxPrev  <= rxSync;
            rxState <= rxStateNext;
            baudCnt <= baudCntNext;
            bitCnt  <= bitCntNext;
            rxShift <= rxShiftNext;
        end
    end

    always_comb begin
        rxStateNext = rxState;
        baudCntNext = baudCnt + 1'b1;
        bitCntNext  = bitCnt;
        rxShiftNext = rxShift;
        byteValid   = 1'b0;
        frameErr    = 1'b0;
        case (rxState)
            RX_IDLE: begin
                baudCntNext = '0;
                if (rxPrev && !rxSync) rxStateNext = RX_START;
            end
            RX_START: begin
                // Mid-start re-check rejects short glitches on the line.
                if (baudCnt == BAUD_W'(HALF - 1)) begin
                    baudCntNext = '0;
                    bitCntNext  = '0;
                    rxStateNext = rxSync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (baudCnt == BAUD_W'(DIV - 1)) begin
                    baudCntNext = '0;
                    rxShiftNext = {rxSync, rxShift[7:1]};
                    bitCntNext  = bitCnt + 1'b1;
                    if (bitCnt == 3'd7) rxStateNext = RX_STOP;
                end
            end
            RX_STOP: begin
                if (baudCnt == BAUD_W'(DIV - 1)) begin
                    rxStateNext = RX_IDLE;
                    byteValid   = rxSync;
                    frameErr    = !rxSync;
                end
            end
            default: rxStateNext = RX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------ frame parser
    typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, CSUM} state_t;

    state_t            state, stateNext;
    logic              initDone;
    logic              cpuRstn, cpuRstnNext;
    logic              busy, busyNext;
    logic              done, doneNext;
    logic              err, errNext;
    logic              we, weNext;
    logic [ADDR_W-1:0] addr, addrNext;
    logic [31:0]       wdata, wdataNext;
    logic [23:0]       asmReg, asmNext;
    logic [7:0]        csum, csumNext;
    logic [7:0]        nLo, nLoNext;
    logic [15:0]       nWords, nWordsNext;
    logic [15:0]       wordIdx, wordIdxNext;
    logic [1:0]        byteIdx, byteIdxNext;
    logic [TMR_W-1:0]  timer, timerNext;
    logic              rxByte, rxBad, fail;

    assign rxByte = byteValid & load_en_i;
    assign rxBad  = frameErr & load_en_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            initDone <= 1'b0;
            cpuRstn  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            we       <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
            asmReg   <= '0;
            csum     <= '0;
            nLo      <= '0;
            nWords   <= '0;
            wordIdx  <= '0;
            byteIdx  <= '0;
            timer    <= '0;
        end else begin
            state    <= stateNext;
            initDone <= 1'b1;
            cpuRstn  <= cpuRstnNext;
            busy     <= busyNext;
            done     <= doneNext;
            err      <= errNext;
            we       <= weNext;
            addr     <= addrNext;
            wdata    <= wdataNext;
            asmReg   <= asmNext;
            csum     <= csumNext;
            nLo      <= nLoNext;
            nWords   <= nWordsNext;
            wordIdx  <= wordIdxNext;
            byteIdx  <= byteIdxNext;
            timer    <= timerNext;
        end
    end

    always_comb begin
        stateNext   = state;
        cpuRstnNext = cpuRstn;
        busyNext    = busy;
        doneNext    = done;
        errNext     = err;
        weNext      = 1'b0;
        addrNext    = we ? addr + 1'b1 : addr;
        wdataNext   = wdata;
        asmNext     = asmReg;
        csumNext    = csum;
        nLoNext     = nLo;
        nWordsNext  = nWords;
        wordIdxNext = wordIdx;
        byteIdxNext = byteIdx;
        timerNext   = (state == IDLE || rxByte) ? '0 : timer + 1'b1;
        fail        = 1'b0;

        // The CPU comes out of reset once after power-up; afterwards only a good frame releases it.
        if (!initDone) cpuRstnNext = 1'b1;

        if (!load_en_i) begin
            if (state != IDLE) begin
                stateNext = IDLE;
                busyNext  = 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (rxByte && rxShift == 8'hA5) begin
                        stateNext   = CNT_LO;
                        cpuRstnNext = 1'b0;
                        busyNext    = 1'b1;
                        doneNext    = 1'b0;
                        errNext     = 1'b0;
                        addrNext    = '0;
                        csumNext    = '0;
                        byteIdxNext = '0;
                        wordIdxNext = '0;
                    end
                end
                CNT_LO: begin
                    if (rxByte) begin
                        nLoNext   = rxShift;
                        stateNext = CNT_HI;
                    end
                end
                CNT_HI: begin
                    if (rxByte) begin
                        nWordsNext = {rxShift, nLo};
                        if ({1'b0, rxShift, nLo} > MAX_WORDS) fail = 1'b1;
                        else if ({rxShift, nLo} == 16'd0)     stateNext = CSUM;
                        else                                  stateNext = DATA;
                    end
                end
                DATA: begin
                    if (rxByte) begin
                        csumNext    = csum + rxShift;
                        asmNext     = {rxShift, asmReg[23:8]};
                        byteIdxNext = byteIdx + 1'b1;
                        if (byteIdx == 2'd3) begin
                            weNext      = 1'b1;
                            wdataNext   = {rxShift, asmReg};
                            wordIdxNext = wordIdx + 16'd1;
                            if (wordIdx + 16'd1 == nWords) stateNext = CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (rxByte) begin
                        if (rxShift == csum) begin
                            doneNext    = 1'b1;
                            busyNext    = 1'b0;
                            cpuRstnNext = 1'b1;
                            stateNext   = IDLE;
                        end else begin
                            fail = 1'b1;
                        end
                    end
                end
                default: stateNext = IDLE;
            endcase

            if (state != IDLE && (rxBad || timer == TMR_W'(TIMEOUT_CYC))) fail = 1'b1;

            if (fail) begin
                stateNext = IDLE;
                errNext   = 1'b1;
                busyNext  = 1'b0;
            end
        end
    end

    assign imem_we_o    = we;
    assign imem_addr_o  = addr;
    assign imem_wdata_o = wdata;
    assign cpu_rstn_o   = cpuRstn;
    assign busy_o       = busy;
    assign done_o       = done;
    assign err_o        = err;

endmodule

// File: doc/uart_imem_loader.md
Name: uart_imem_loader

Overview:
- Sits upstream of the pipelined CPU top level.
- Receives a program image over a UART line and writes it word by word into instruction memory through a write port.
- Holds the CPU in reset while a load is in progress and releases it after a frame with a good checksum.
- Lets new programs be loaded on the board without resynthesis.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- BAUD, 115200, UART bit rate. DIV = CLK_HZ/BAUD (integer division), DIV >= 4.
- ADDR_W, 8, instruction-memory word-address width. Capacity is 2^ADDR_W words.
- TIMEOUT_CYC, 2000000, idle cycles allowed between bytes inside a frame before the frame is aborted.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- uart_rx_i  in  1  UART RX line, asynchronous, idle high.
- load_en_i  in  1  load mode enable (board switch). When 0, the UART is ignored.
- imem_we_o  out  1  instruction-memory write strobe, one-cycle pulse.
- imem_addr_o  out  ADDR_W  word address for the write.
- imem_wdata_o  out  32  word to write.
- cpu_rstn_o  out  1  active-low reset to the CPU.
- busy_o  out  1  frame in progress.
- done_o  out  1  sticky: last frame loaded successfully.
- err_o  out  1  sticky: last frame failed.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rstn). All flops clear asynchronously.
- Reset values: imem_we_o=0, imem_addr_o=0, imem_wdata_o=0, cpu_rstn_o=0, busy_o=0, done_o=0, err_o=0.
- cpu_rstn_o after reset release:
  - load_en_i=0: cpu_rstn_o goes 1 on the first clock edge after rstn deasserts, and stays 1. The UART is ignored and no writes are issued.
  - load_en_i=1: cpu_rstn_o also goes 1 after reset. The loader FSM then controls it.
- UART RX:
  - 2-flop synchronizer on uart_rx_i.
  - A falling edge starts a byte. At DIV/2 the line is re-sampled; if it is high, the start is treated as a glitch and the receiver returns to idle.
  - 8 data bits are sampled LSB first, one every DIV cycles.
  - The stop bit is sampled at DIV. If it is 0, this is a framing error: the byte is discarded and the error handling below applies.
  - A good byte produces a one-cycle byte_valid internally.
- Frame format, all little-endian: sync 0xA5, N_lo, N_hi, then N*4 data bytes, then a checksum byte. Checksum = 8-bit sum modulo 256 of the data bytes only.
- Frame FSM states: IDLE, CNT_LO, CNT_HI, DATA, CSUM.
  - IDLE: a byte of 0xA5 starts a frame.
    - cpu_rstn_o<=0, busy_o<=1, done_o<=0, err_o<=0.
    - Address and checksum cleared. Go to CNT_LO.
    - Any other byte is ignored.
  - CNT_LO: latch N_lo. Go to CNT_HI.
  - CNT_HI: latch N_hi.
    - If N > 2^ADDR_W: error.
    - If N == 0: go to CSUM.
    - Otherwise: go to DATA.
  - DATA:
    - Shift bytes into a 32-bit assembly register, first byte = bits[7:0].
    - Add each byte to the checksum.
    - On the 4th byte, the next cycle drives imem_we_o=1 for exactly one cycle with the word on imem_wdata_o and the current address on imem_addr_o. The address then increments.
    - After word N-1 is written, go to CSUM.
  - CSUM:
    - Match: done_o<=1, busy_o<=0, cpu_rstn_o<=1 on the next cycle, go to IDLE.
    - Mismatch: error.
- Error (count too large, checksum mismatch, framing error in a non-IDLE state, or timeout):
  - err_o<=1, busy_o<=0, go to IDLE.
  - cpu_rstn_o stays 0 until a later good frame.
  - Words already written stay in instruction memory.
- Framing error in IDLE: the byte is discarded and no flag changes.
- Timeout: a counter runs in every non-IDLE state and clears on each byte_valid. When it reaches TIMEOUT_CYC, this is an error.
- load_en_i dropping to 0 mid-frame aborts to IDLE without setting err_o. cpu_rstn_o is left unchanged.
- While cpu_rstn_o=0, only imem_we_o writes occur. No other handshake exists. Instruction memory must accept one write per cycle.
- rstn asserted mid-frame: immediate return to reset values. A partially received byte is lost.

Test Plan (CLK_HZ=16, BAUD=1 so DIV=16, ADDR_W=4, TIMEOUT_CYC=400):
- load_en_i=0, release rstn, send frame A5 01 00 13 00 00 00 13 -> cpu_rstn_o=1 one cycle after release; no imem_we_o pulses; done_o=0.
- load_en_i=1, frame A5 02 00 13 00 00 00 B3 00 50 00 16 -> cpu_rstn_o falls after 0xA5; writes addr0=0x00000013 and addr1=0x005000B3, one pulse each; then done_o=1, cpu_rstn_o=1, busy_o=0.
- Same frame with checksum 0x17 -> err_o=1, done_o=0, cpu_rstn_o stays 0. Resending the good frame then gives done_o=1, err_o=0, cpu_rstn_o=1.
- A5 02 00 13 00 00 00 followed by silence -> one write to addr0; 400 cycles after the last byte err_o=1 and busy_o=0. Frame A5 00 00 00 then gives done_o=1 with no writes.
- A5 11 00 (N=17 > 16) -> err_o=1 immediately after N_hi, no writes. A byte with stop bit 0 inside DATA -> err_o=1.
- rstn pulsed low during DATA -> all outputs at reset values. The next good frame writes starting at addr0.
